// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and state encoding for the UART TX scheduler.
package uart_tx_sched_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ALU_WIDTH_DEF  = 16;

  localparam logic [1:0] ST_IDLE_C  = 2'b00;
  localparam logic [1:0] ST_HOLD_C  = 2'b01;
  localparam logic [1:0] ST_DRAIN_C = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_C,
    HOLD  = ST_HOLD_C,
    DRAIN = ST_DRAIN_C
  } sched_state_e;

endpackage

// File: rtl/tx_req_slot.sv
// One-deep holding slot for a TX requester. A load into a full slot that is
// not being released in the same cycle is dropped and flagged for one cycle.
module tx_req_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         release_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Slot occupancy and payload: release and load together keeps the new data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_o  = 1'b0;
    if (load_i && (!valid_q || release_i)) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else begin
      if (release_i) begin
        valid_d = 1'b0;
      end
      if (load_i) begin
        drop_o = 1'b1;
      end
    end
  end

  // Slot registers, emptied by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares the UART TX channel between register-file bytes and 16-bit ALU
// results. Each byte is presented with a level data-valid that is held until
// the UART reports busy, then dropped before the UART can return to idle.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ALU_WIDTH  = ALU_WIDTH_DEF
) (
  input  logic                  CLK_FSM,
  input  logic                  RST_FSM,
  input  logic                  RF_RD_VLD,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  ALU_OUT_VLD,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  SCHED_BUSY,
  output logic                  OVF
);

  sched_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  hi_pend_q, hi_pend_d;
  logic                  ovf_q, ovf_d;

  logic                  rf_valid, alu_valid;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [ALU_WIDTH-1:0]  alu_data;
  logic                  rf_drop, alu_drop;
  logic                  rf_rel, alu_rel;

  tx_req_slot #(.W(DATA_WIDTH)) u_rf_slot (
    .clk_i     (CLK_FSM),
    .rst_n_i   (RST_FSM),
    .load_i    (RF_RD_VLD),
    .data_i    (RF_RD_DATA),
    .release_i (rf_rel),
    .valid_o   (rf_valid),
    .data_o    (rf_data),
    .drop_o    (rf_drop)
  );

  tx_req_slot #(.W(ALU_WIDTH)) u_alu_slot (
    .clk_i     (CLK_FSM),
    .rst_n_i   (RST_FSM),
    .load_i    (ALU_OUT_VLD),
    .data_i    (ALU_OUT),
    .release_i (alu_rel),
    .valid_o   (alu_valid),
    .data_o    (alu_data),
    .drop_o    (alu_drop)
  );

  // Arbitration (RF before ALU), byte sequencing and BUSY handshake.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    hi_d      = hi_q;
    hi_pend_d = hi_pend_q;
    rf_rel    = 1'b0;
    alu_rel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rf_valid) begin
          tx_data_d = rf_data;
          tx_vld_d  = 1'b1;
          rf_rel    = 1'b1;
          state_d   = HOLD;
        end else if (alu_valid) begin
          tx_data_d = alu_data[DATA_WIDTH-1:0];
          hi_d      = alu_data[ALU_WIDTH-1:DATA_WIDTH];
          hi_pend_d = 1'b1;
          tx_vld_d  = 1'b1;
          alu_rel   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!TX_BUSY) begin
          if (hi_pend_q) begin
            tx_data_d = hi_q;
            tx_vld_d  = 1'b1;
            hi_pend_d = 1'b0;
            state_d   = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        tx_data_d = '0;
        tx_vld_d  = 1'b0;
        hi_pend_d = 1'b0;
      end
    endcase
  end

  // Overflow is sticky until reset.
  always_comb begin
    ovf_d = ovf_q | rf_drop | alu_drop;
  end

  // State, output and pending-byte registers; reset aborts any transfer.
  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      hi_q      <= '0;
      hi_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      hi_q      <= hi_d;
      hi_pend_q <= hi_pend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign SCHED_BUSY = (state_q != IDLE);
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple UART TX busy model.
module tb_uart_tx_sched;

  logic        CLK_FSM = 1'b0;
  logic        RST_FSM;
  logic        RF_RD_VLD;
  logic [7:0]  RF_RD_DATA;
  logic        ALU_OUT_VLD;
  logic [15:0] ALU_OUT;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        SCHED_BUSY;
  logic        OVF;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frames[$];
  logic       model_en;

  uart_tx_sched #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
    .CLK_FSM     (CLK_FSM),
    .RST_FSM     (RST_FSM),
    .RF_RD_VLD   (RF_RD_VLD),
    .RF_RD_DATA  (RF_RD_DATA),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .ALU_OUT     (ALU_OUT),
    .TX_BUSY     (TX_BUSY),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .SCHED_BUSY  (SCHED_BUSY),
    .OVF         (OVF)
  );

  always #5 CLK_FSM = ~CLK_FSM;

  // UART TX model: takes the byte when data-valid is seen, busy rises
  // 3 cycles later and stays high for 20 cycles.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK_FSM);
      if (model_en && TX_D_VLD) begin
        frames.push_back(TX_P_DATA);
        repeat (3) @(negedge CLK_FSM);
        TX_BUSY = 1'b1;
        repeat (20) @(negedge CLK_FSM);
        TX_BUSY = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_FSM);
    #1;
  endtask

  task automatic pulse_rf(input logic [7:0] d);
    RF_RD_VLD  = 1'b1;
    RF_RD_DATA = d;
    tick();
    RF_RD_VLD  = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    ALU_OUT_VLD = 1'b1;
    ALU_OUT     = d;
    tick();
    ALU_OUT_VLD = 1'b0;
  endtask

  // Waits (sampling after the falling edge) for TX_BUSY to reach lvl.
  task automatic wait_busy(input logic lvl, input int maxc, input string tag);
    int c = 0;
    while (TX_BUSY !== lvl && c < maxc) begin
      @(negedge CLK_FSM);
      #1;
      c++;
    end
    chk(tag, TX_BUSY, lvl);
  endtask

  // Waits until n frames were taken and everything is quiet again.
  task automatic wait_done(input int n, input int maxc, input string tag);
    int c = 0;
    while (!(frames.size() == n && !SCHED_BUSY && !TX_BUSY) && c < maxc) begin
      @(negedge CLK_FSM);
      #1;
      c++;
    end
    chk(tag, frames.size(), n);
  endtask

  initial begin
    int c;
    int idle_cnt;
    int bad;
    RST_FSM     = 1'b0;
    RF_RD_VLD   = 1'b0;
    RF_RD_DATA  = '0;
    ALU_OUT_VLD = 1'b0;
    ALU_OUT     = '0;
    model_en    = 1'b1;
    #1;
    chk("rst_dvld", TX_D_VLD, 0);
    chk("rst_pdata", TX_P_DATA, 8'h00);
    chk("rst_sbusy", SCHED_BUSY, 0);
    chk("rst_ovf", OVF, 0);
    repeat (3) tick();
    RST_FSM = 1'b1;
    tick();

    // Single RF byte A5
    frames.delete();
    pulse_rf(8'hA5);
    chk("rf_dvld_n1", TX_D_VLD, 0);
    tick();
    chk("rf_dvld_n2", TX_D_VLD, 1);
    chk("rf_pdata_n2", TX_P_DATA, 8'hA5);
    chk("rf_sbusy_n2", SCHED_BUSY, 1);
    wait_busy(1'b1, 10, "rf_busy_rise");
    chk("rf_dvld_before_edge", TX_D_VLD, 1);
    tick();
    chk("rf_dvld_fall", TX_D_VLD, 0);
    chk("rf_sbusy_drain", SCHED_BUSY, 1);
    wait_busy(1'b0, 40, "rf_busy_fall");
    chk("rf_sbusy_at_fall", SCHED_BUSY, 1);
    tick();
    chk("rf_sbusy_after", SCHED_BUSY, 0);
    wait_done(1, 50, "rf_nframes");
    chk("rf_frame0", frames[0], 8'hA5);

    // ALU 1234: two back-to-back bytes
    frames.delete();
    pulse_alu(16'h1234);
    c = 0;
    while (frames.size() < 1 && c < 20) begin
      @(negedge CLK_FSM); #1; c++;
    end
    idle_cnt = 0;
    c = 0;
    while (frames.size() < 2 && c < 100) begin
      @(negedge CLK_FSM); #1; c++;
      if (!SCHED_BUSY) idle_cnt++;
    end
    chk("alu_no_idle_gap", idle_cnt, 0);
    wait_done(2, 100, "alu_nframes");
    chk("alu_frame0", frames[0], 8'h34);
    chk("alu_frame1", frames[1], 8'h12);
    chk("alu_ovf", OVF, 0);

    // Same-cycle RF 5A and ALU BEEF
    frames.delete();
    RF_RD_VLD   = 1'b1;
    RF_RD_DATA  = 8'h5A;
    ALU_OUT_VLD = 1'b1;
    ALU_OUT     = 16'hBEEF;
    tick();
    RF_RD_VLD   = 1'b0;
    ALU_OUT_VLD = 1'b0;
    wait_done(3, 300, "both_nframes");
    chk("both_frame0", frames[0], 8'h5A);
    chk("both_frame1", frames[1], 8'hEF);
    chk("both_frame2", frames[2], 8'hBE);
    chk("both_ovf", OVF, 0);

    // RF overflow while the channel is occupied by an ALU transfer
    frames.delete();
    pulse_alu(16'h0102);
    tick();
    chk("ovf_hold", SCHED_BUSY, 1);
    pulse_rf(8'h11);
    chk("ovf_after_first", OVF, 0);
    tick();
    pulse_rf(8'h22);
    chk("ovf_set", OVF, 1);
    wait_done(3, 300, "ovf_nframes");
    chk("ovf_frame0", frames[0], 8'h02);
    chk("ovf_frame1", frames[1], 8'h01);
    chk("ovf_frame2", frames[2], 8'h11);
    chk("ovf_sticky", OVF, 1);
    repeat (5) tick();
    chk("ovf_no_extra", frames.size(), 3);

    // Reset during DRAIN of the ALU lo byte
    frames.delete();
    pulse_alu(16'hCAFE);
    wait_busy(1'b1, 20, "rst_busy_rise");
    tick();
    chk("rst_pre_sbusy", SCHED_BUSY, 1);
    chk("rst_pre_pdata", TX_P_DATA, 8'hFE);
    #2 RST_FSM = 1'b0;
    #1;
    chk("rst_async_dvld", TX_D_VLD, 0);
    chk("rst_async_pdata", TX_P_DATA, 8'h00);
    chk("rst_async_sbusy", SCHED_BUSY, 0);
    chk("rst_async_ovf", OVF, 0);
    repeat (2) tick();
    RST_FSM = 1'b1;
    repeat (40) tick();
    chk("rst_nframes", frames.size(), 1);
    chk("rst_idle_dvld", TX_D_VLD, 0);
    chk("rst_idle_sbusy", SCHED_BUSY, 0);

    // UART never goes busy: hold data stable for 50 cycles
    frames.delete();
    model_en = 1'b0;
    pulse_rf(8'h3C);
    tick();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h3C || SCHED_BUSY !== 1'b1) bad++;
      tick();
    end
    chk("stall_stable", bad, 0);
    model_en = 1'b1;
    wait_done(1, 60, "stall_nframes");
    chk("stall_frame0", frames[0], 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
